// File: rtl/matrix_feeder_skew.sv
// Operand staging for the SxS systolic array: holds A by rows and B by
// columns, then replays them as diagonally skewed wavefronts.
module matrix_feeder_skew #(
  parameter int N = 2,
  parameter int S = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(S)-1:0] wr_row,
  input  logic [S*N-1:0]       wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 sn,
  output logic [S*N-1:0]       A0,
  output logic [S*N-1:0]       B0
);

  localparam int W  = S * N;
  localparam int RW = $clog2(S);
  localparam int TW = $clog2(3 * S - 2);
  localparam logic [TW-1:0] T_LAST = TW'(3 * S - 3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_t;
  logic            r_busy;
  logic            r_done;
  logic            r_sn;
  logic [W-1:0]    r_a0;
  logic [W-1:0]    r_b0;

  // r_a[i][k] = A[i][k], r_b[k][j] = B[k][j]
  logic [N-1:0]    r_a [S][S];
  logic [N-1:0]    r_b [S][S];

  state_t          w_ns;
  logic [TW-1:0]   w_nt;
  logic [W-1:0]    w_a_nxt;
  logic [W-1:0]    w_b_nxt;
  logic            w_row_ok;
  logic            w_wr;
  int              w_d;

  assign w_row_ok = ({1'b0, wr_row} < (RW + 1)'(S));
  assign w_wr     = wr_en && w_row_ok && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < S; i++) begin
        for (int k = 0; k < S; k++) begin
          r_a[i][k] <= '0;
          r_b[i][k] <= '0;
        end
      end
    end else if (w_wr) begin
      for (int k = 0; k < S; k++) begin
        if (!wr_sel) begin
          r_a[wr_row][k] <= wr_data[W-1-k*N -: N];
        end else begin
          r_b[k][wr_row] <= wr_data[W-1-k*N -: N];
        end
      end
    end
  end

  always_comb begin
    w_ns = r_state;
    w_nt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_ns = ST_CLR;
      end
      ST_CLR: begin
        w_ns = ST_STREAM;
      end
      ST_STREAM: begin
        if (r_t == T_LAST) w_ns = ST_DONE;
        else w_nt = r_t + 1'b1;
      end
      ST_DONE: begin
        w_ns = ST_IDLE;
      end
      default: begin
        w_ns = ST_IDLE;
      end
    endcase
  end

  // Lane values for the upcoming cycle; drain slots fall out of range
  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    w_d     = 0;
    if (w_ns == ST_STREAM) begin
      for (int i = 0; i < S; i++) begin
        w_d = int'(w_nt) - i;
        if (w_d >= 0 && w_d < S) begin
          w_a_nxt[W-1-i*N -: N] = r_a[i][w_d[RW-1:0]];
          w_b_nxt[W-1-i*N -: N] = r_b[w_d[RW-1:0]][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sn    <= 1'b0;
      r_a0    <= '0;
      r_b0    <= '0;
    end else begin
      r_state <= w_ns;
      r_t     <= w_nt;
      r_busy  <= (w_ns != ST_IDLE);
      r_done  <= (w_ns == ST_DONE);
      r_sn    <= (w_ns == ST_CLR);
      r_a0    <= w_a_nxt;
      r_b0    <= w_b_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sn   = r_sn;
  assign A0   = r_a0;
  assign B0   = r_b0;

endmodule
